out_spike_buf: RTL

//  Output-side counterpart of the core's input spike buffer. Collects per-neuron

---
 rtl/out_spike_buf.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/out_spike_buf.sv
`default_nettype none
// ============================================================================
// Module      : out_spike_buf
// Description : Output spike buffer. Collects per-neuron output spikes written
//               serially during a timestep into a collection buffer. On
//               start_i the collection buffer is snapshotted into a transmit
//               buffer, and every set bit is sent to the local router as one
//               packet {SRC_X, SRC_Y, neuron index} over a valid/ready link.
//               Collection of timestep t+1 overlaps transmission of t.
// Ports       : clk_i, rst_n_i (async, active-low)
//               start_i              timestep boundary pulse
//               wrEn_spike_i,
//               neuronAddr_i,
//               spike_i              serial spike write port
//               pkt_valid_o,
//               pkt_data_o,
//               pkt_ready_i          packet link to router
//               spike_out_o          copy of the last accepted snapshot
//               busy_o               scan/transmit in progress
//               done_o               1-cycle pulse when a snapshot is finished
//               overrun_o            sticky: start_i seen while busy
// Revision    : 1.0 - initial release
// ============================================================================
module out_spike_buf #(
    parameter int NUM_NEURONS          = 256,
    parameter int NEURON_CNT_BIT_WIDTH = 8,
    parameter int COORD_W              = 4,
    parameter int SRC_X                = 0,
    parameter int SRC_Y                = 0,
    parameter int PKT_W                = 2*COORD_W + NEURON_CNT_BIT_WIDTH
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            start_i,
    input  logic                            wrEn_spike_i,
    input  logic [NEURON_CNT_BIT_WIDTH-1:0] neuronAddr_i,
    input  logic                            spike_i,
    output logic                            pkt_valid_o,
    output logic [PKT_W-1:0]                pkt_data_o,
    input  logic                            pkt_ready_i,
    output logic [NUM_NEURONS-1:0]          spike_out_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            overrun_o
);

    localparam logic [NEURON_CNT_BIT_WIDTH-1:0] PTR_LAST =
        NEURON_CNT_BIT_WIDTH'(NUM_NEURONS - 1);
    localparam logic [COORD_W-1:0] SRC_X_F = COORD_W'(SRC_X);
    localparam logic [COORD_W-1:0] SRC_Y_F = COORD_W'(SRC_Y);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t                          state_q,     state_d;
    logic [NUM_NEURONS-1:0]          col_q,       col_d;
    logic [NUM_NEURONS-1:0]          tx_q,        tx_d;
    logic [NUM_NEURONS-1:0]          spike_out_q, spike_out_d;
    logic [NEURON_CNT_BIT_WIDTH-1:0] ptr_q,       ptr_d;
    logic                            valid_q,     valid_d;
    logic [PKT_W-1:0]                data_q,      data_d;
    logic                            busy_q,      busy_d;
    logic                            done_q,      done_d;
    logic                            overrun_q,   overrun_d;

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        tx_d        = tx_q;
        spike_out_d = spike_out_q;
        ptr_d       = ptr_q;
        valid_d     = valid_q;
        data_d      = data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;

        // Collection side. The clear on start_i comes first so that a write
        // in the same cycle lands in the next timestep's buffer.
        if (start_i) begin
            col_d = '0;
        end
        if (wrEn_spike_i && (32'(neuronAddr_i) < NUM_NEURONS)) begin
            col_d[neuronAddr_i] = spike_i;
        end

        // Snapshot source is col_q, i.e. the buffer before this cycle's
        // write, which keeps a same-cycle write out of the snapshot.
        if (start_i) begin
            if (state_q == ST_IDLE) begin
                tx_d        = col_q;
                spike_out_d = col_q;
                ptr_d       = '0;
                busy_d      = 1'b1;
                state_d     = ST_SCAN;
            end else begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            ST_SCAN: begin
                if (tx_q[ptr_q]) begin
                    valid_d = 1'b1;
                    data_d  = {SRC_X_F, SRC_Y_F, ptr_q};
                    state_d = ST_SEND;
                end else if (ptr_q == PTR_LAST) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (pkt_ready_i) begin
                    valid_d = 1'b0;
                    if (ptr_q == PTR_LAST) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = ST_SCAN;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            tx_q        <= '0;
            spike_out_q <= '0;
            ptr_q       <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            tx_q        <= tx_d;
            spike_out_q <= spike_out_d;
            ptr_q       <= ptr_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign pkt_valid_o = valid_q;
    assign pkt_data_o  = data_q;
    assign spike_out_o = spike_out_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign overrun_o   = overrun_q;

endmodule
`default_nettype wire
